// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: loader FSM states and default instruction store geometry.
// Used by the instruction loader, the instruction memory and the fetch stage.
package fetch_pkg;

    localparam int BYTE_WIDTH                = 8;
    localparam int PC_WIDTH_DEFAULT          = 19;
    localparam int MEMORY_SIZE_DEFAULT       = 1024;
    localparam int INSTRUCTION_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } loader_state_t;

    function automatic int bytes_per_word(input int width);
        return width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word shift register for the instruction loader.
// word is the value the buffer takes with the byte being accepted; word_valid marks the last byte.
module byte_assembler
    import fetch_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accept,
    input  logic [BYTE_WIDTH-1:0]        byte_data,
    output logic [INSTRUCTION_WIDTH-1:0] word,
    output logic                         word_valid
);

    localparam int BPW       = bytes_per_word(INSTRUCTION_WIDTH);
    localparam int IDX_WIDTH = (BPW > 1) ? $clog2(BPW) : 1;

    logic [INSTRUCTION_WIDTH-1:0] shift_q;
    logic [IDX_WIDTH-1:0]         idx_q;
    logic                         last;

    assign last = (idx_q == IDX_WIDTH'(BPW - 1));

    // Earlier bytes move toward the MSBs, so the first byte ends up in the top byte lane.
    assign word       = (shift_q << BYTE_WIDTH) | INSTRUCTION_WIDTH'(byte_data);
    assign word_valid = accept && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            shift_q <= word;
            idx_q   <= last ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Writer side of the instruction store: assembles host bytes into words and writes them
// to consecutive addresses from 0, holding the core stalled (busy) while a session runs.
module instruction_loader
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH          = PC_WIDTH_DEFAULT,
    parameter int MEMORY_SIZE       = MEMORY_SIZE_DEFAULT,
    parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PC_WIDTH-1:0]          word_count,
    input  logic                         byte_valid,
    input  logic [BYTE_WIDTH-1:0]        byte_data,
    output logic                         byte_ready,
    output logic                         mem_we,
    output logic [PC_WIDTH-1:0]          mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam logic [PC_WIDTH-1:0] MAX_COUNT = PC_WIDTH'(MEMORY_SIZE);

    loader_state_t                state_q;
    logic [PC_WIDTH-1:0]          count_q;
    logic [PC_WIDTH-1:0]          addr_q;
    logic [INSTRUCTION_WIDTH-1:0] word;
    logic                         word_valid;
    logic                         accept;

    assign accept = byte_valid && byte_ready;

    byte_assembler #(
        .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)
    ) u_byte_assembler (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (word),
        .word_valid(word_valid)
    );

    // All outputs are registered and updated on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q <= word_count;
                        addr_q  <= '0;
                        error   <= 1'b0;
                        if (word_count == '0) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else if (word_count > MAX_COUNT) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        state_q    <= WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= addr_q;
                        mem_wdata  <= word;
                    end
                end
                WRITE: begin
                    if (addr_q == count_q - 1'b1) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        addr_q     <= addr_q + 1'b1;
                        state_q    <= LOAD;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table-driven sessions, hand-written corner
// cases and randomized sessions compared against a word-packing reference model.
module tb_instruction_loader;

    localparam int PW = 19;
    localparam int MS = 1024;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] word_count;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [PW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    instruction_loader #(
        .PC_WIDTH(PW),
        .MEMORY_SIZE(MS),
        .INSTRUCTION_WIDTH(IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word_count(word_count),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int errors = 0;
    int checks = 0;

    int            cyc = 0;
    logic [PW-1:0] wr_addr_q[$];
    logic [IW-1:0] wr_data_q[$];
    int            last_wr_cyc = 0;
    int            done_cnt    = 0;
    int            done_cyc    = 0;
    int            we_ready_overlap = 0;
    logic [7:0]    tx_bytes[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_we && byte_ready) we_ready_overlap++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: word i is bytes 4i..4i+3 packed most-significant first.
    function automatic logic [IW-1:0] model_word(input int i);
        logic [IW-1:0] w = '0;
        for (int k = 0; k < IW / 8; k++) w = (w << 8) | IW'(tx_bytes[i * (IW / 8) + k]);
        return w;
    endfunction

    function automatic int model_writes(input logic [PW-1:0] wc);
        return (wc == 0 || wc > MS) ? 0 : int'(wc);
    endfunction

    task automatic fill_random(input int nwords);
        tx_bytes.delete();
        for (int i = 0; i < nwords * (IW / 8); i++) tx_bytes.push_back(8'($urandom));
    endtask

    task automatic run_session(input logic [PW-1:0] wc, input int gap, input int poke,
                               input int exp_writes, input bit exp_err);
        int budget;
        int busy_bad  = 0;
        int ready_bad = 0;
        int nbytes    = exp_writes * (IW / 8);
        int n;
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        start = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
        word_count = PW'($urandom);
        check("error_after_start", error, exp_err);
        if (exp_writes == 0) check("done_next_cycle", done, 1);
        else                 check("busy_after_start", busy, 1);
        for (int i = 0; i < nbytes; i++) begin
            for (int g = 0; g < gap; g++) begin
                byte_valid = 1'b0;
                tick();
                if (!busy) busy_bad++;
            end
            byte_valid = 1'b1;
            byte_data  = tx_bytes[i];
            if (i == poke) begin
                start = 1'b1;
                word_count = 5;
            end
            budget = 0;
            while (!byte_ready && budget < 10) begin
                tick();
                budget++;
                if (!busy) busy_bad++;
            end
            if (budget >= 10) check("byte_ready_timeout", 0, 1);
            if (gap > 0 && budget != 0) ready_bad++;
            tick();
            start = 1'b0;
            byte_valid = 1'b0;
            if (!busy) busy_bad++;
        end
        budget = 0;
        while (!done && budget < 20) begin
            tick();
            budget++;
        end
        check("done_seen", done, 1);
        check("busy_in_done", busy, 0);
        tick();
        check("done_pulse_width", done, 0);
        check("done_count", done_cnt, 1);
        check("write_count", wr_addr_q.size(), exp_writes);
        n = (wr_addr_q.size() < exp_writes) ? wr_addr_q.size() : exp_writes;
        for (int i = 0; i < n; i++) begin
            check($sformatf("write_addr[%0d]", i), wr_addr_q[i], i);
            check($sformatf("write_data[%0d]", i), wr_data_q[i], model_word(i));
        end
        if (exp_writes > 0 && n == exp_writes)
            check("done_after_last_write", done_cyc - last_wr_cyc, 1);
        check("busy_held", busy_bad, 0);
        if (gap > 0) check("ready_held_in_load", ready_bad, 0);
        check("error_sticky", error, exp_err);
    endtask

    typedef struct {
        logic [PW-1:0] wc;
        int            gap;
        int            exp_writes;
        bit            exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{wc: 3,    gap: 0, exp_writes: 3,    exp_err: 1'b0};
        vecs[1] = '{wc: 5,    gap: 1, exp_writes: 5,    exp_err: 1'b0};
        vecs[2] = '{wc: 1024, gap: 0, exp_writes: 1024, exp_err: 1'b0};
        vecs[3] = '{wc: 1,    gap: 2, exp_writes: 1,    exp_err: 1'b0};
        vecs[4] = '{wc: 1026, gap: 0, exp_writes: 0,    exp_err: 1'b1};
        vecs[5] = '{wc: 0,    gap: 0, exp_writes: 0,    exp_err: 1'b0};
        vecs[6] = '{wc: 2,    gap: 4, exp_writes: 2,    exp_err: 1'b0};

        rst = 1'b1;
        start = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_byte_ready", byte_ready, 0);
        check("reset_error", error, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        tick();

        // Basic load with fixed data, back-to-back and stalled.
        tx_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
        run_session(2, 0, -1, 2, 1'b0);
        if (wr_data_q.size() == 2) begin
            check("basic_word0", wr_data_q[0], 32'hDEADBEEF);
            check("basic_word1", wr_data_q[1], 32'h00000013);
        end
        run_session(2, 3, -1, 2, 1'b0);
        check("mem_data_held", mem_wdata, 32'h00000013);

        // Empty and oversized loads; a later good start clears the sticky error.
        run_session(0, 0, -1, 0, 1'b0);
        run_session(1025, 0, -1, 0, 1'b1);
        repeat (3) tick();
        check("error_still_set", error, 1);
        fill_random(1);
        run_session(1, 0, -1, 1, 1'b0);

        // Reset in the middle of a word.
        fill_random(1);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        start = 1'b1;
        word_count = 1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            byte_valid = 1'b1;
            byte_data = tx_bytes[i];
            tick();
        end
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", byte_ready, 0);
        repeat (5) tick();
        check("rst_mid_no_write", wr_addr_q.size(), 0);
        check("rst_mid_no_done", done_cnt, 0);
        tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_session(1, 0, -1, 1, 1'b0);
        if (wr_data_q.size() == 1) check("after_rst_word", wr_data_q[0], 32'h11223344);

        // A start during LOAD must not extend or restart the session.
        fill_random(1);
        run_session(1, 0, 2, 1, 1'b0);
        repeat (20) tick();
        check("ignored_start_busy", busy, 0);
        check("ignored_start_writes", wr_addr_q.size(), 1);

        for (int v = 0; v < 7; v++) begin
            fill_random(vecs[v].exp_writes);
            run_session(vecs[v].wc, vecs[v].gap, -1, vecs[v].exp_writes, vecs[v].exp_err);
        end

        for (int r = 0; r < 8; r++) begin
            logic [PW-1:0] wc;
            int            gap;
            if (r == 7) wc = PW'(MS + 1 + $urandom_range(0, 5000));
            else        wc = PW'($urandom_range(0, 8));
            gap = $urandom_range(0, 2);
            fill_random(model_writes(wc));
            run_session(wc, gap, -1, model_writes(wc), wc > MS);
        end

        check("we_never_with_ready", we_ready_overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction memory: receives a byte stream from an external host link (UART/JTAG bridge) and assembles it into instruction words.
- Writes each completed word into consecutive instruction memory addresses starting at 0.
- Holds the core stalled while loading.
- Sits between the host link and the write port of the instruction store that the fetch stage reads by PC.

Parameters:
- PC_WIDTH, 19, width of the word address (matches fetch PC width).
- MEMORY_SIZE, 1024, number of instruction words in the store.
- INSTRUCTION_WIDTH, 32, instruction word width; must be a multiple of 8.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load session; sampled only in IDLE.
- word_count  input  PC_WIDTH  number of words to load; sampled with start.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  PC_WIDTH  word write address.
- mem_wdata  output  INSTRUCTION_WIDTH  word write data.
- busy  output  1  session in progress; also the core stall/hold.
- done  output  1  one-cycle pulse at the end of a session.
- error  output  1  sticky flag for an illegal word_count; cleared by rst or the next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, word counter 0, byte index 0, assembly buffer 0.
- Byte order: first byte of a word goes to bits [W-1:W-8] (big-endian); BPW = INSTRUCTION_WIDTH/8 bytes per word.
- IDLE:
  - byte_ready = 0, busy = 0.
  - On start, latch word_count, clear error.
  - word_count == 0 → DONE.
  - word_count > MEMORY_SIZE → set error, go to DONE, no writes.
  - Otherwise → LOAD with addr = 0.
- LOAD:
  - byte_ready = 1, busy = 1.
  - Each accepted byte shifts into the buffer and increments the byte index.
  - The transfer that completes byte BPW moves to WRITE; the byte index returns to 0.
  - byte_valid low simply stalls; there is no timeout.
- WRITE:
  - Exactly one cycle: mem_we = 1, mem_addr = current addr, mem_wdata = assembled word, byte_ready = 0.
  - If addr == count-1 → DONE, else addr++ → LOAD.
- DONE: done = 1 for one cycle, busy = 0, → IDLE.
- Latency and throughput:
  - mem_we asserts the cycle after the last byte of a word is accepted.
  - Minimum BPW+1 cycles per word.
- mem_we is asserted only in WRITE. mem_addr and mem_wdata are held stable outside WRITE (last values).
- start while not in IDLE is ignored; word_count changes mid-session are ignored.
- rst mid-session: immediate return to IDLE, partial word discarded, no write, no done pulse.
- Address never exceeds MEMORY_SIZE-1, guaranteed by the word_count check; no wrap-around.
- byte_valid asserted in IDLE/WRITE/DONE: not accepted (byte_ready = 0); the source must hold the byte.

Decomposition:
- Shared package fetch_pkg:
  - state enum loader_state_t {IDLE, LOAD, WRITE, DONE}.
  - BYTE_WIDTH = 8.
  - Default PC_WIDTH / MEMORY_SIZE / INSTRUCTION_WIDTH constants, shared with the instruction memory and fetch.
- One natural sub-module, byte_assembler: shift register plus byte index, producing word and word_valid. The FSM and address counter stay in instruction_loader.

Test Plan:
- Basic load: start, word_count=2, bytes DE AD BE EF 00 00 00 13 back-to-back → mem_we at addr 0 = 0xDEADBEEF and addr 1 = 0x00000013; done pulses the cycle after the second write; busy 1 from the cycle after start until done.
- Stalled stream: same data with byte_valid low 3 cycles between every byte → identical writes; byte_ready stays 1 throughout LOAD; no extra mem_we.
- Empty load: start, word_count=0 → done the cycle after start, mem_we never asserted, error 0.
- Oversized load: start, word_count=1025 → error = 1, done pulse, no mem_we. A later start with word_count=1 clears error.
- Reset mid-word: start, word_count=1, send 2 bytes, pulse rst → busy 0, no mem_we, no done. A new session sending 11 22 33 44 writes 0x11223344 to addr 0.
- Ignored start: assert start with word_count=5 during LOAD of a 1-word session → session ends after 1 write; the second start has no effect.
